// File: rtl/lcd_msg_arbiter_if.sv
// Bus between the LCD message requesters and lcd_msg_arbiter.
// The requester side (master) drives iREQ/iMSG; the arbiter (slave) drives
// the registered message code, one-hot grant, update pulse and busy flag.
// dbg_state mirrors the arbiter FSM (0 = IDLE, 1 = HOLD) for observation.
// Handshake: iREQ[i] is a level; a requester holds it until it sees oGNT[i]
// (or longer to keep the display). oGNT is the only acknowledge.
interface lcd_msg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int MSG_W = 4
);
    logic [N_REQ-1:0]       iREQ;
    logic [N_REQ*MSG_W-1:0] iMSG;
    logic [MSG_W-1:0]       oMENSAJE;
    logic [N_REQ-1:0]       oGNT;
    logic                   oUPDATE;
    logic                   oBUSY;
    logic                   dbg_state;

    modport master (
        output iREQ, iMSG,
        input  oMENSAJE, oGNT, oUPDATE, oBUSY, dbg_state
    );

    modport slave (
        input  iREQ, iMSG,
        output oMENSAJE, oGNT, oUPDATE, oBUSY, dbg_state
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: shares the 2x16 LCD between N_REQ requesters.
// One requester is granted at a time; its code is registered onto oMENSAJE
// and held for at least HOLD_CYCLES cycles so it stays readable. With no
// requester active the display shows IDLE_MSG.
// Optional macro LCD_ARB_RR_EN: round-robin arbitration (search starts after
// the last granted index). Without it, the lowest requesting index wins.
module lcd_msg_arbiter #(
    parameter int              N_REQ       = 4,
    parameter int              MSG_W       = 4,
    parameter int              HOLD_CYCLES = 50000000,
    parameter int              CNT_W       = 26,
    parameter logic [MSG_W-1:0] IDLE_MSG   = '0
) (
    input  logic              iCLK,
    input  logic              iRST,
    lcd_msg_arbiter_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               upd_q, upd_d;
    logic               busy_q, busy_d;

    logic               any_req;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_onehot;
    logic [MSG_W-1:0]   win_msg;
    logic               load;

`ifdef LCD_ARB_RR_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    // Round-robin search: first requester strictly after the last winner.
    always_comb begin : rr_search
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!any_req && bus.iREQ[idx]) begin
                any_req = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    // Pointer follows every load of a new grant or code.
    always_comb begin
        ptr_d = load ? win_idx : ptr_q;
    end

    // Pointer register; reset so index 0 is searched first.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) ptr_q <= IDX_W'(N_REQ - 1);
        else      ptr_q <= ptr_d;
    end
`else
    // Fixed priority: scan from the top so the lowest set index wins last.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.iREQ[i]) begin
                any_req = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Decode the winner into a grant vector and pick its message code.
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_msg             = bus.iMSG[int'(win_idx)*MSG_W +: MSG_W];
    end

    // Next-state logic: load on IDLE exit or on a changed winner/code at expiry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        msg_d   = msg_q;
        gnt_d   = gnt_q;
        upd_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) load = 1'b1;
            end
            S_HOLD: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end else if (!any_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    msg_d   = IDLE_MSG;
                    upd_d   = 1'b1;
                end else if (win_onehot != gnt_q || win_msg != msg_q) begin
                    load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d = S_HOLD;
            gnt_d   = win_onehot;
            msg_d   = win_msg;
            upd_d   = 1'b1;
            timer_d = HOLD_RELOAD;
        end
        busy_d = (state_d == S_HOLD) && (timer_d != '0);
    end

    // State and output registers; reset forces the idle display immediately.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            msg_q   <= IDLE_MSG;
            gnt_q   <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            msg_q   <= msg_d;
            gnt_q   <= gnt_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.oMENSAJE  = msg_q;
    assign bus.oGNT      = gnt_q;
    assign bus.oUPDATE   = upd_q;
    assign bus.oBUSY     = busy_q;
    assign bus.dbg_state = state_q;

endmodule
